// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//   Bundles the operand-side and result-side handshakes of serial_adder.
//   Optional macro: SERIAL_ADDER_OVF_EN adds the ovf result signal.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. A producer holds valid and its payload
//   stable until that edge. A consumer may drive ready independently of valid.
//
//   Signals
//     in_valid  master->slave  operands valid
//     in_ready  slave->master  adder can accept operands
//     a, b      master->slave  WIDTH-bit operands
//     cin       master->slave  carry into bit 0
//     out_valid slave->master  result valid
//     out_ready master->slave  consumer accepts result
//     sum       slave->master  a+b+cin, low WIDTH bits
//     cout      slave->master  carry out of bit WIDTH-1
//     ovf       slave->master  signed overflow (SERIAL_ADDER_OVF_EN only)
// ---------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. Accepts two WIDTH-bit operands plus a carry-in and adds
//   one bit per clock, LSB first, through a single full-adder with its carry
//   registered and fed back. One operation in flight; WIDTH RUN cycles.
//   Optional macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        serial_adder_if.slave (operand and result handshakes)
//     dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_if.slave        bus,
    output logic [1:0]           dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The one full-adder cell of the datapath; returns {carry, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        full_adder = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_shift;

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        cnt_d     = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        {fa_c, fa_s} = full_adder(a_sr_q[0], b_sr_q[0], carry_q);
        // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
        // Written this way so WIDTH=1 needs no zero-width slice.
        sum_shift            = sum_sr_q >> 1;
        sum_shift[WIDTH-1]   = fa_s;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = sum_shift;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Visible result only changes here, never mid-operation.
                    sum_d   = sum_shift;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this last cycle.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder: WIDTH=8 instance for directed and
//   random back-to-back traffic, plus a WIDTH=1 instance for the exhaustive
//   single-bit case. Optional macro: SERIAL_ADDER_OVF_EN also checks ovf.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();
    logic [1:0] dbg8;
    logic [1:0] dbg1;

    serial_adder #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave), .dbg_state(dbg8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state(dbg1));

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, sum} packed at
    // bits [w+1], [w], [w-1:0]; ovf only when the feature is built in.
    function automatic logic [31:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
        longint full;
        longint ua;
        longint ub;
        longint total;
        logic [31:0] r;
        full  = longint'(1) << w;
        ua    = longint'(a) & (full - 1);
        ub    = longint'(b) & (full - 1);
        total = ua + ub + longint'(cin);
        r     = 32'(total);
`ifdef SERIAL_ADDER_OVF_EN
        begin
            longint half;
            longint sa;
            longint sb;
            longint st;
            half = full >> 1;
            sa   = (ua >= half) ? ua - full : ua;
            sb   = (ub >= half) ? ub - full : ub;
            st   = sa + sb + longint'(cin);
            if (st >= half || st < -half) r[w+1] = 1'b1;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] res8();
        logic [31:0] r;
        r = 32'({if8.cout, if8.sum});
`ifdef SERIAL_ADDER_OVF_EN
        r[W+1] = if8.ovf;
`endif
        return r;
    endfunction

    function automatic logic [31:0] res1();
        logic [31:0] r;
        r = 32'({if1.cout, if1.sum});
`ifdef SERIAL_ADDER_OVF_EN
        r[2] = if1.ovf;
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out8(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!if8.out_valid && n < 40);
    endtask

    // Issues one operation and leaves the DUT in DONE (out_ready low).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input string tag);
        int n;
        if8.a = a;
        if8.b = b;
        if8.cin = cin;
        if8.in_valid = 1'b1;
        check({tag, "_ready"}, 32'(if8.in_ready), 32'd1);
        step();
        if8.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(if8.in_ready), 32'd0);
        wait_out8(n);
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_result"}, res8(), model(W, 32'(a), 32'(b), cin));
    endtask

    task automatic release_out(input string tag);
        if8.out_ready = 1'b1;
        step();
        if8.out_ready = 1'b0;
        check({tag, "_ovalid_low"}, 32'(if8.out_valid), 32'd0);
        check({tag, "_iready_back"}, 32'(if8.in_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held;
        int acc;
        int got;
        int last_acc;
        int cyc;
        logic change;
        int n;

        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_result", res8(), 32'd0);
        check("rst_state", 32'(dbg8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(if8.in_ready), 32'd1);

        // Directed: mixed carries, signed overflow case
        run_op(8'h5A, 8'h3C, 1'b0, "op5a3c");
        check("op5a3c_sum", 32'(if8.sum), 32'h96);
        held = res8();
        // Stall in DONE: outputs stable, in_valid ignored
        for (int i = 0; i < 5; i++) begin
            if8.in_valid = 1'b1;
            if8.a = 8'($urandom_range(0, 255));
            if8.b = 8'($urandom_range(0, 255));
            step();
            check("stall_ovalid", 32'(if8.out_valid), 32'd1);
            check("stall_iready", 32'(if8.in_ready), 32'd0);
            check("stall_result", res8(), held);
        end
        if8.in_valid = 1'b0;
        release_out("op5a3c");
        check("idle_keeps_result", res8(), held);

        // Directed: carry ripples through every bit
        run_op(8'hFF, 8'h00, 1'b1, "opff00");
        release_out("opff00");

        // Async reset mid-RUN at cnt=3
        if8.a = 8'h77; if8.b = 8'h11; if8.cin = 1'b1; if8.in_valid = 1'b1;
        step();
        if8.in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("midrst_ovalid", 32'(if8.out_valid), 32'd0);
        check("midrst_iready", 32'(if8.in_ready), 32'd1);
        check("midrst_result", res8(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(8'h01, 8'h01, 1'b0, "after_rst");
        check("after_rst_sum", 32'(if8.sum), 32'h02);
        release_out("after_rst");

        // Back-to-back random traffic with both valid and ready held high
        acc = 0; got = 0; last_acc = -1; cyc = 0; change = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
        if8.in_valid = 1'b1;
        if8.out_ready = 1'b1;
        while (got < 1000 && cyc < 20000) begin
            if (change) begin
                change = 1'b0;
                if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
                if (acc == 1000) if8.in_valid = 1'b0;
            end
            if (if8.out_valid && if8.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious_out", 32'd1, 32'd0);
                end else begin
                    check("b2b_result", res8(), exp_q.pop_front());
                end
                got++;
            end
            if (if8.in_valid && if8.in_ready) begin
                exp_q.push_back(model(W, 32'(if8.a), 32'(if8.b), if8.cin));
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
                last_acc = cyc;
                acc++;
                change = 1'b1;
            end
            step();
            cyc++;
        end
        check("b2b_completed", 32'(got), 32'd1000);
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b0;
        step();

        // WIDTH=1 instance: every {cin,b,a} combination
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            if1.a = v[0];
            if1.b = v[1];
            if1.cin = v[2];
            if1.in_valid = 1'b1;
            step();
            if1.in_valid = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (!if1.out_valid && n < 10);
            check("w1_latency", 32'(n), 32'd1);
            check("w1_popcount", 32'({if1.cout, if1.sum}), 32'($countones(v)));
            check("w1_result", res1(), model(1, 32'(v[0]), 32'(v[1]), v[2]));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
